laser_receiver: RTL and testbench
=================================

# laser_receiver

Receive end of the laser beam-break link: samples the asynchronous photodiode comparator output and resynchronises and debounces it. A state machine then tracks whether the beam is present, and flags and counts beam-break events. It sits opposite the laser transmitter, which holds the beam on after reset, and feeds the sensor status logic with a clean level, a one-cycle break pulse and a saturating event count.

## Interface
- DEBOUNCE_CYCLES, 16, consecutive cycles a new level must persist before it is accepted (≥2)
- LOSS_TIMEOUT, 1024, cycles in BROKEN before declaring beam lost (≥2)
- CNT_W, 16, width of break_count
- clk  in  1  system clock; one clock domain
- rst  in  1  synchronous, active-high reset
- photo_in  in  1  raw photodiode comparator output, asynchronous; 1 = light received
- clear_count  in  1  synchronous clear of break_count
- beam_ok  out  1  debounced beam present, qualified by FSM; reset 0
- break_pulse  out  1  one-cycle pulse per accepted break; reset 0
- beam_lost  out  1  level, beam absent ≥ LOSS_TIMEOUT cycles; reset 0
- break_count  out  CNT_W  accepted breaks, saturating; reset 0

## Operation
- Input path: 2-flop synchroniser (sync). Debounce register filt resets to 0. A mismatch counter counts consecutive cycles with sync != filt.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, filt takes sync and the counter clears.
  - When sync == filt, the counter clears.
- FSM states: ACQUIRE (reset state), BEAM_OK, BROKEN, LOST.
  - ACQUIRE: on a filt rise → BEAM_OK, with no pulse and no count.
  - BEAM_OK: on a filt fall → BROKEN; assert break_pulse and increment break_count.
  - BROKEN: on a filt rise → BEAM_OK. The loss timer increments each cycle in BROKEN; when it reaches LOSS_TIMEOUT → LOST.
  - LOST: on a filt rise → BEAM_OK, with no pulse and no count.
- Loss timer clears on every entry to BROKEN and is idle outside BROKEN.
- Outputs are registered decodes of the FSM:
  - beam_ok = (state == BEAM_OK).
  - beam_lost = (state == LOST).
  - break_pulse is high for exactly the one cycle after the BEAM_OK→BROKEN transition.
- break_count saturates at all-ones; further breaks still pulse but do not wrap.
- clear_count coinciding with an increment gives break_count = 1, so no event is lost. clear_count alone gives 0.
- rst mid-operation: all state, counters, filt and the synchroniser return to reset values on the next edge. A beam present during reset is re-acquired silently via ACQUIRE.

## Timing
- Latency from a stable photo_in change to the FSM output change is 2 (sync) + DEBOUNCE_CYCLES (filt) + 1 (registered output) cycles.
- A glitch shorter than DEBOUNCE_CYCLES cycles at sync has no effect on any output.
- From the break_pulse cycle, beam_ok is already 0 and beam_lost rises LOSS_TIMEOUT cycles later.
- Back-to-back breaks are limited by the debounce window: at least 2×DEBOUNCE_CYCLES cycles between break_pulse assertions.

## Configuration
- LASER_RX_GLITCH_CNT_EN defined:
  - Adds output glitch_count [CNT_W-1:0], reset 0, saturating.
  - It increments when a non-zero mismatch run ends with sync == filt, i.e. the run is rejected.
  - clear_count also clears it, with the same coincidence rule as break_count.
- Undefined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Shared package laser_pkg holds:
  - the FSM state enum (ACQUIRE, BEAM_OK, BROKEN, LOST);
  - the default constants for DEBOUNCE_CYCLES and LOSS_TIMEOUT.
- One sub-module, laser_debounce: the synchroniser plus debounce filter.
  - Ports: clk, rst, raw_in, level_out, and glitch_evt (used only under the macro).
  - The FSM and counters stay in laser_receiver.

## Test plan
Run all scenarios with DEBOUNCE_CYCLES=4, LOSS_TIMEOUT=16, CNT_W=8.
- Reset with photo_in=1, release rst → beam_ok=1 seven cycles after release; break_pulse never fires; break_count=0.
- From BEAM_OK, photo_in 1→0 held → break_pulse high one cycle, seven cycles after the edge; break_count=1; beam_ok=0.
- photo_in low pulses of 1, 2 and 3 cycles in BEAM_OK → no output change. With the macro, glitch_count=3.
- photo_in held 0 for 40 cycles → beam_lost=1 exactly 16 cycles after break_pulse. photo_in back to 1 → beam_lost=0 and beam_ok=1 seven cycles later; break_count unchanged.
- 256 breaks → break_count saturates at 255. Then clear_count coinciding with the next break → break_count=1.
- Assert rst while in BROKEN with the loss timer at 10 → all outputs 0 next cycle; FSM in ACQUIRE; beam_lost does not assert.

Source files
------------

// File: rtl/laser_pkg.sv
// laser_pkg: receiver FSM states and default timing constants
package laser_pkg;
    typedef enum logic [1:0] {ACQUIRE, BEAM_OK, BROKEN, LOST} state_t;
    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_LOSS_TIMEOUT = 1024;
endpackage

// File: rtl/laser_debounce.sv
// laser_debounce: 2-flop synchroniser plus persistence filter; glitch_evt flags a rejected mismatch run
module laser_debounce import laser_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level_out,
    output logic glitch_evt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [1:0] sync_q, sync_d;
    logic filt_q, filt_d, sync, accept;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        sync = sync_q[1];
        sync_d = {sync_q[0], raw_in};
        accept = sync != filt_q && cnt_q + 1'b1 == CW'(DEBOUNCE_CYCLES);
        filt_d = accept ? sync : filt_q;
        cnt_d = (sync == filt_q || accept) ? '0 : cnt_q + 1'b1;
        glitch_evt = sync == filt_q && cnt_q != '0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= 2'b00;
            filt_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            sync_q <= sync_d;
            filt_q <= filt_d;
            cnt_q <= cnt_d;
        end
    end
    assign level_out = filt_q;
endmodule

// File: rtl/laser_receiver.sv
// laser_receiver: beam-break FSM with break pulse, loss timeout and saturating counters (LASER_RX_GLITCH_CNT_EN adds glitch_count)
module laser_receiver import laser_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int LOSS_TIMEOUT = DEF_LOSS_TIMEOUT,
    parameter int CNT_W = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic photo_in,
    input  logic clear_count,
    output logic beam_ok,
    output logic break_pulse,
    output logic beam_lost,
    output logic [CNT_W-1:0] break_count
`ifdef LASER_RX_GLITCH_CNT_EN
    ,
    output logic [CNT_W-1:0] glitch_count
`endif
);
    localparam int TW = $clog2(LOSS_TIMEOUT + 1);
    state_t state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] bcnt_q, bcnt_d;
    logic beam_ok_q, beam_lost_q, pulse_q;
    logic filt, glitch_evt, brk, timeout;
    laser_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
        .clk(clk),
        .rst(rst),
        .raw_in(photo_in),
        .level_out(filt),
        .glitch_evt(glitch_evt)
    );
    always_comb begin
        brk = state_q == BEAM_OK && !filt;
        timeout = state_q == BROKEN && timer_q + 1'b1 == TW'(LOSS_TIMEOUT);
        state_d = filt ? BEAM_OK : brk ? BROKEN : timeout ? LOST : state_q;
        timer_d = (state_q == BROKEN && !filt && !timeout) ? timer_q + 1'b1 : '0;
        bcnt_d = clear_count ? CNT_W'(brk) : bcnt_q + CNT_W'(brk && !(&bcnt_q));
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ACQUIRE;
            timer_q <= '0;
            bcnt_q <= '0;
            beam_ok_q <= 1'b0;
            beam_lost_q <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            bcnt_q <= bcnt_d;
            beam_ok_q <= state_d == BEAM_OK;
            beam_lost_q <= state_d == LOST;
            pulse_q <= brk;
        end
    end
    assign beam_ok = beam_ok_q;
    assign beam_lost = beam_lost_q;
    assign break_pulse = pulse_q;
    assign break_count = bcnt_q;
`ifdef LASER_RX_GLITCH_CNT_EN
    logic [CNT_W-1:0] gcnt_q, gcnt_d;
    always_comb gcnt_d = clear_count ? CNT_W'(glitch_evt) : gcnt_q + CNT_W'(glitch_evt && !(&gcnt_q));
    always_ff @(posedge clk) gcnt_q <= rst ? '0 : gcnt_d;
    assign glitch_count = gcnt_q;
`else
    logic unused_glitch;
    assign unused_glitch = glitch_evt;
`endif
endmodule

// File: tb/tb_laser_receiver.sv
// tb_laser_receiver: directed plus random stimulus against a rule-level reference model
module tb_laser_receiver;
    localparam int DB = 4;
    localparam int LT = 16;
    localparam int CW = 8;
    localparam int MAX = 255;
    logic clk = 1'b0, rst = 1'b1, photo_in = 1'b1, clear_count = 1'b0;
    logic beam_ok, break_pulse, beam_lost;
    logic [CW-1:0] break_count;
`ifdef LASER_RX_GLITCH_CNT_EN
    logic [CW-1:0] glitch_count;
`endif
    int nvec = 0, nerr = 0, cyc = 0, brk_cyc = 0, m_bc = 0, m_gc = 0;
    logic m_s1, m_s2, m_filt, m_pend, m_ok, m_broken, m_lost, m_pulse;
    bit sh[$];

    laser_receiver #(.DEBOUNCE_CYCLES(DB), .LOSS_TIMEOUT(LT), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .photo_in(photo_in),
        .clear_count(clear_count),
        .beam_ok(beam_ok),
        .break_pulse(break_pulse),
        .beam_lost(beam_lost),
        .break_count(break_count)
`ifdef LASER_RX_GLITCH_CNT_EN
        ,
        .glitch_count(glitch_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Filter rule: the level is accepted once the last DB synchronised samples all agree.
    task automatic model(input logic r, input logic p, input logic c);
        logic f_old, s, brk, evt, same;
        cyc++;
        if (r) begin
            {m_s1, m_s2, m_filt, m_pend, m_ok, m_broken, m_lost, m_pulse} = '0;
            sh.delete();
            m_bc = 0;
            m_gc = 0;
            return;
        end
        f_old = m_filt;
        s = m_s2;
        brk = m_ok && !f_old;
        m_pulse = brk;
        if (f_old) begin
            m_ok = 1; m_broken = 0; m_lost = 0;
        end else if (brk) begin
            m_ok = 0; m_broken = 1; brk_cyc = cyc;
        end else if (m_broken && cyc - brk_cyc >= LT) begin
            m_broken = 0; m_lost = 1;
        end
        m_bc = c ? int'(brk) : (brk && m_bc < MAX) ? m_bc + 1 : m_bc;
        sh.push_back(s);
        if (sh.size() > DB) void'(sh.pop_front());
        same = sh.size() == DB;
        foreach (sh[i]) if (sh[i] != s) same = 0;
        evt = s == f_old && m_pend;
        if (same) m_filt = s;
        m_pend = s != f_old && m_filt == f_old;
        m_gc = c ? int'(evt) : (evt && m_gc < MAX) ? m_gc + 1 : m_gc;
        m_s2 = m_s1;
        m_s1 = p;
    endtask

    task automatic step(input logic p, input logic c);
        photo_in = p;
        clear_count = c;
        @(posedge clk);
        model(rst, p, c);
        #1;
        chk("beam_ok", beam_ok, m_ok);
        chk("beam_lost", beam_lost, m_lost);
        chk("break_pulse", break_pulse, m_pulse);
        chk("break_count", break_count, m_bc);
`ifdef LASER_RX_GLITCH_CNT_EN
        chk("glitch_count", glitch_count, m_gc);
`endif
    endtask

    initial begin
        // Reset with beam present, then silent acquisition after 7 cycles
        repeat (3) step(1, 0);
        chk("rst_beam_ok", beam_ok, 0);
        chk("rst_count", break_count, 0);
        rst = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step(1, 0);
            chk("acq_latency", beam_ok, i == 7);
        end
        repeat (3) step(1, 0);
        chk("acq_no_count", break_count, 0);
        // Break held 40 cycles: pulse at 7, lost 16 cycles later
        for (int i = 1; i <= 40; i++) begin
            step(0, 0);
            chk("brk_pulse_time", break_pulse, i == 7);
            chk("lost_time", beam_lost, i >= 23);
        end
        chk("brk_count", break_count, 1);
        chk("brk_beam_ok", beam_ok, 0);
        for (int i = 1; i <= 7; i++) begin
            step(1, 0);
            chk("reacq_ok", beam_ok, i == 7);
            chk("reacq_lost", beam_lost, i < 7);
        end
        chk("reacq_count", break_count, 1);
        // Short low glitches are rejected
        for (int l = 1; l <= 3; l++) begin
            repeat (l) step(0, 0);
            repeat (8) step(1, 0);
        end
        chk("glitch_beam_ok", beam_ok, 1);
        chk("glitch_count_brk", break_count, 1);
`ifdef LASER_RX_GLITCH_CNT_EN
        chk("glitch_total", glitch_count, 3);
`endif
        // Random runs with occasional clears
        repeat (60) begin
            logic v;
            int len;
            v = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 10);
            repeat (len) step(v, $urandom_range(0, 19) == 0);
        end
        repeat (10) step(1, 0);
        step(1, 1);
        chk("clear_alone", break_count, 0);
        // Saturation then clear coinciding with a break
        repeat (256) begin
            repeat (7) step(0, 0);
            repeat (7) step(1, 0);
        end
        chk("sat_count", break_count, 255);
        repeat (6) step(0, 0);
        step(0, 1);
        chk("sat_pulse", break_pulse, 1);
        chk("clear_coincide", break_count, 1);
        // Reset in BROKEN with the loss timer at 10
        repeat (10) step(0, 0);
        rst = 1'b1;
        step(0, 0);
        chk("mid_rst_ok", beam_ok, 0);
        chk("mid_rst_lost", beam_lost, 0);
        chk("mid_rst_pulse", break_pulse, 0);
        chk("mid_rst_count", break_count, 0);
        rst = 1'b0;
        for (int i = 1; i <= 30; i++) begin
            step(0, 0);
            chk("acq_never_lost", beam_lost, 0);
        end
        for (int i = 1; i <= 7; i++) begin
            step(1, 0);
            chk("post_rst_ok", beam_ok, i == 7);
            chk("post_rst_pulse", break_pulse, 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
